// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one outstanding access to a
// single-cycle word RAM, with byte-lane steering and load extension.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  ram_ce,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_nx;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  req_err;
    logic                  f3_bad;
    logic                  mis_h;
    logic                  mis_w;
    logic                  out_range;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           load_data;

    assign accept = req_valid && req_ready;

    // Upper address bits beyond the RAM window are only checked, never latched.
    always_comb begin
        f3_bad    = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                           : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        mis_h     = (req_funct3[1:0] == 2'b01) && req_addr[0];
        mis_w     = (req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00);
        out_range = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
        req_err   = f3_bad || mis_h || mis_w || out_range;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = req_err ? RESP : ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lane_b = ram_dout[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_data = {24'd0, lane_b};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = ram_dout;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[ADDR_WIDTH+1:0];
                wdata_q <= req_wdata;
                rdata_q <= 32'd0;
                err_q   <= req_err;
            end
            if (state == ACCESS && !we_q) rdata_q <= load_data;
        end
    end

    // Gating with rst keeps a write from committing while reset is high.
    always_comb begin
        ram_ce = (state == ACCESS) && !rst;
        ram_we = 4'b0000;
        if (ram_ce && we_q) begin
            case (f3_q[1:0])
                2'b00:   ram_we = 4'b0001 << addr_q[1:0];
                2'b01:   ram_we = 4'b0011 << addr_q[1:0];
                default: ram_we = 4'b1111;
            endcase
        end
        case (f3_q[1:0])
            2'b00:   ram_din = {4{wdata_q[7:0]}};
            2'b01:   ram_din = {2{wdata_q[15:0]}};
            default: ram_din = wdata_q;
        endcase
    end

    assign ram_addr   = addr_q[ADDR_WIDTH+1:2];
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-lane RAM model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_ce;
    logic [3:0]  ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] mem [0:255];
    int          tests = 0;
    int          fails = 0;
    int          ce_count = 0;

    lsu_mem_ctrl #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr[7:0]];

    always @(posedge clk) begin
        if (ram_ce) begin
            ce_count <= ce_count + 1;
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_din[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic ok_txn(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_we, input logic [15:0] exp_addr,
                          input logic [31:0] exp_din, input logic [31:0] exp_rdata);
        start(we, f3, addr, wdata);
        check({tag, "_ce"}, 32'(ram_ce), 32'd1);
        check({tag, "_we"}, 32'(ram_we), 32'(exp_we));
        check({tag, "_addr"}, 32'(ram_addr), 32'(exp_addr));
        if (we) check({tag, "_din"}, ram_din, exp_din);
        check({tag, "_early_valid"}, 32'(resp_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_err"}, 32'(resp_err), 32'd0);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_resp_ce"}, 32'(ram_ce), 32'd0);
        step();
    endtask

    task automatic err_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
        int ce0;
        ce0 = ce_count;
        start(we, f3, addr, 32'hFFFF_FFFF);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_err"}, 32'(resp_err), 32'd1);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        check({tag, "_ce"}, 32'(ram_ce), 32'd0);
        step();
        check({tag, "_ce_count"}, 32'(ce_count), 32'(ce0));
        check({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4] = 32'h1111_1111;

        step();
        step();
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_ce", 32'(ram_ce), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_din", ram_din, 32'd0);
        rst = 1'b0;
        step();
        check("rst_ready", 32'(req_ready), 32'd1);

        ok_txn("sw8", 1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 4'hF, 16'd2, 32'hDEAD_BEEF, 32'd0);
        ok_txn("lw8", 1'b0, 3'b010, 32'h8, 32'd0, 4'h0, 16'd2, 32'd0, 32'hDEAD_BEEF);
        ok_txn("sw8b", 1'b1, 3'b010, 32'h8, 32'h80FF_7F01, 4'hF, 16'd2, 32'h80FF_7F01, 32'd0);
        ok_txn("lb9", 1'b0, 3'b000, 32'h9, 32'd0, 4'h0, 16'd2, 32'd0, 32'h0000_007F);
        ok_txn("lbuB", 1'b0, 3'b100, 32'hB, 32'd0, 4'h0, 16'd2, 32'd0, 32'h0000_0080);
        ok_txn("lbB", 1'b0, 3'b000, 32'hB, 32'd0, 4'h0, 16'd2, 32'd0, 32'hFFFF_FF80);
        ok_txn("lhA", 1'b0, 3'b001, 32'hA, 32'd0, 4'h0, 16'd2, 32'd0, 32'hFFFF_80FF);
        ok_txn("lhuA", 1'b0, 3'b101, 32'hA, 32'd0, 4'h0, 16'd2, 32'd0, 32'h0000_80FF);
        ok_txn("sb6", 1'b1, 3'b000, 32'h6, 32'h1234_5678, 4'b0100, 16'd1, 32'h7878_7878, 32'd0);
        ok_txn("sh6", 1'b1, 3'b001, 32'h6, 32'h1234_5678, 4'b1100, 16'd1, 32'h5678_5678, 32'd0);
        ok_txn("lw4", 1'b0, 3'b010, 32'h4, 32'd0, 4'h0, 16'd1, 32'd0, 32'h5678_0000);
        ok_txn("lw0", 1'b0, 3'b010, 32'h0, 32'd0, 4'h0, 16'd0, 32'd0, 32'd0);

        err_txn("e_lw2", 1'b0, 3'b010, 32'h2);
        err_txn("e_sh1", 1'b1, 3'b001, 32'h1);
        err_txn("e_f3_011", 1'b0, 3'b011, 32'h0);
        err_txn("e_range", 1'b0, 3'b010, 32'h0004_0000);
        err_txn("e_st_f3", 1'b1, 3'b100, 32'h0);

        resp_ready = 1'b0;
        start(1'b0, 3'b010, 32'h8, 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, 32'h80FF_7F01);
            check("hold_ready", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        check("hold_release_valid", 32'(resp_valid), 32'd0);
        check("hold_release_ready", 32'(req_ready), 32'd1);

        start(1'b1, 3'b010, 32'h10, 32'hA5A5_A5A5);
        check("rst_acc_ce", 32'(ram_ce), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_acc_ce_drop", 32'(ram_ce), 32'd0);
        check("rst_acc_we_drop", 32'(ram_we), 32'd0);
        check("rst_acc_addr", 32'(ram_addr), 32'd0);
        check("rst_acc_din", ram_din, 32'd0);
        step();
        rst = 1'b0;
        check("rst_acc_mem4", mem[4], 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            check("rst_acc_no_valid", 32'(resp_valid), 32'd0);
            step();
        end
        check("rst_acc_ready", 32'(req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
